// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding, grant owner and SRAM address width.
package sram_arbiter_pkg;
  localparam int SRAM_AW = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;
endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the external 16-bit SRAM between a byte-wide CPU port and a word-wide DMA port,
// sequencing strobes, byte lanes and a one-cycle bus turnaround after every access.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAITS     = 2,
  parameter int CPU_BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [19:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ready,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [SRAM_AW-1:0] dma_addr,
  input  logic [15:0]        dma_wdata,
  output logic [15:0]        dma_rdata,
  output logic               dma_ack,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_cen,
  output logic               sram_oen,
  output logic               sram_wen,
  output logic               sram_ubn,
  output logic               sram_lbn
);
  localparam int WCW = (WAITS > 1) ? $clog2(WAITS) : 1;
  localparam int BCW = $clog2(CPU_BURST + 1);

  state_t         state, state_nxt;
  gnt_t           gnt, gnt_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [BCW-1:0] burst_cnt;
  logic           cur_we;
  logic           cur_lsb;
  logic           start;
  logic           start_we;
  logic           last;

  assign last = (wait_cnt == WCW'(WAITS - 1));

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    start     = 1'b0;
    start_we  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          start     = 1'b1;
          state_nxt = ACCESS;
          // DMA only overtakes a pending CPU request once the burst allowance is used up
          gnt_nxt   = (dma_req && (!cpu_req || burst_cnt == BCW'(CPU_BURST))) ? GNT_DMA : GNT_CPU;
          start_we  = (gnt_nxt == GNT_DMA) ? dma_we : cpu_we;
        end
      end
      ACCESS:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= GNT_CPU;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      cur_we     <= 1'b0;
      sram_a     <= '0;
      sram_cen   <= 1'b1;
      sram_oen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_ubn   <= 1'b1;
      sram_lbn   <= 1'b1;
      sram_dq_oe <= 1'b0;
      cpu_ready  <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dma_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (!dma_req) burst_cnt <= '0;
          if (start) begin
            wait_cnt   <= '0;
            cur_we     <= start_we;
            sram_cen   <= 1'b0;
            sram_oen   <= start_we;
            sram_wen   <= ~start_we;
            sram_dq_oe <= start_we;
            if (gnt_nxt == GNT_DMA) begin
              burst_cnt <= '0;
              sram_a    <= dma_addr;
              sram_ubn  <= 1'b0;
              sram_lbn  <= 1'b0;
            end else begin
              if (dma_req) burst_cnt <= burst_cnt + 1'b1;
              // Big-endian byte order: even address lives in the upper lane
              sram_a   <= cpu_addr[19:1];
              sram_ubn <= cpu_addr[0];
              sram_lbn <= ~cpu_addr[0];
            end
          end
        end
        ACCESS: begin
          if (last) begin
            sram_cen   <= 1'b1;
            sram_oen   <= 1'b1;
            sram_wen   <= 1'b1;
            sram_ubn   <= 1'b1;
            sram_lbn   <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (gnt == GNT_DMA) begin
              dma_ack <= 1'b1;
              if (!cur_we) dma_rdata <= sram_dq_i;
            end else begin
              cpu_ready <= 1'b1;
              if (!cur_we) cpu_rdata <= cur_lsb ? sram_dq_i[7:0] : sram_dq_i[15:8];
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Release the write strobe one cycle early so data holds past the rising edge
            if (cur_we && wait_cnt == WCW'(WAITS - 2)) sram_wen <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      sram_dq_o <= (gnt_nxt == GNT_DMA) ? dma_wdata : {cpu_wdata, cpu_wdata};
      cur_lsb   <= cpu_addr[0];
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pin model, transaction-level reference memory and scenario tasks.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int WAITS     = 2;
  localparam int CPU_BURST = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req, cpu_we, cpu_ready;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [18:0] dma_addr, sram_a;
  logic [15:0] dma_wdata, dma_rdata, sram_dq_o, sram_dq_i, sram_cur;
  logic        sram_dq_oe, sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn;

  logic        w1_cpu_req, w1_cpu_we, w1_cpu_ready, w1_dma_req, w1_dma_we, w1_dma_ack;
  logic [19:0] w1_cpu_addr;
  logic [7:0]  w1_cpu_wdata, w1_cpu_rdata;
  logic [18:0] w1_dma_addr, w1_sram_a;
  logic [15:0] w1_dma_wdata, w1_dma_rdata, w1_sram_dq_o, w1_sram_dq_i;
  logic        w1_sram_dq_oe, w1_sram_cen, w1_sram_oen, w1_sram_wen, w1_sram_ubn, w1_sram_lbn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAITS(WAITS), .CPU_BURST(CPU_BURST)) u_dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen),
    .sram_ubn(sram_ubn), .sram_lbn(sram_lbn)
  );

  sram_arbiter #(.WAITS(1), .CPU_BURST(CPU_BURST)) u_dut_w1 (
    .clk(clk), .rstn(rstn),
    .cpu_req(w1_cpu_req), .cpu_we(w1_cpu_we), .cpu_addr(w1_cpu_addr), .cpu_wdata(w1_cpu_wdata),
    .cpu_rdata(w1_cpu_rdata), .cpu_ready(w1_cpu_ready),
    .dma_req(w1_dma_req), .dma_we(w1_dma_we), .dma_addr(w1_dma_addr), .dma_wdata(w1_dma_wdata),
    .dma_rdata(w1_dma_rdata), .dma_ack(w1_dma_ack),
    .sram_a(w1_sram_a), .sram_dq_o(w1_sram_dq_o), .sram_dq_i(w1_sram_dq_i), .sram_dq_oe(w1_sram_dq_oe),
    .sram_cen(w1_sram_cen), .sram_oen(w1_sram_oen), .sram_wen(w1_sram_wen),
    .sram_ubn(w1_sram_ubn), .sram_lbn(w1_sram_lbn)
  );

  // Power-up SRAM contents; word 0x091A2 comes out as 0xA55A
  function automatic logic [15:0] init_word(input logic [18:0] a);
    return a[15:0] ^ 16'h34F8;
  endfunction

  logic [15:0] sram_mem [0:524287];
  bit          sram_wr  [0:524287];

  assign sram_cur  = sram_wr[sram_a] ? sram_mem[sram_a] : init_word(sram_a);
  assign sram_dq_i = (!sram_cen && !sram_oen) ? sram_cur : 16'hDEAD;
  assign w1_sram_dq_i = (!w1_sram_cen && !w1_sram_oen) ? (w1_sram_a[15:0] ^ 16'h1234) : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_cen && !sram_wen && sram_dq_oe) begin
      sram_wr[sram_a]  <= 1'b1;
      sram_mem[sram_a] <= {(!sram_ubn ? sram_dq_o[15:8] : sram_cur[15:8]),
                           (!sram_lbn ? sram_dq_o[7:0]  : sram_cur[7:0])};
    end
  end

  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  function automatic logic [7:0] ref_cpu_byte(input logic [19:0] addr);
    logic [15:0] w;
    w = ref_rd(addr[19:1]);
    return addr[0] ? w[7:0] : w[15:8];
  endfunction

  task automatic ref_cpu_write(input logic [19:0] addr, input logic [7:0] b);
    logic [15:0] w;
    w = ref_rd(addr[19:1]);
    if (addr[0]) w[7:0] = b;
    else w[15:8] = b;
    ref_mem[int'(addr[19:1])] = w;
  endtask

  int          obs_lat, obs_cen_lo, obs_oen_lo, obs_wen_lo, obs_oe_hi;
  bit          obs_unstable, obs_wrong_pulse, obs_timeout, obs_done_ok;
  logic [18:0] obs_a;
  logic        obs_ubn, obs_lbn;
  logic [15:0] obs_dq_o, obs_rdata;

  task automatic xact(input bit is_dma, input bit we, input logic [19:0] caddr,
                      input logic [18:0] daddr, input logic [15:0] wd);
    @(posedge clk); #1;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = daddr; dma_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = caddr; cpu_wdata = wd[7:0];
    end
    obs_lat = 0; obs_cen_lo = 0; obs_oen_lo = 0; obs_wen_lo = 0; obs_oe_hi = 0;
    obs_unstable = 1'b0; obs_wrong_pulse = 1'b0; obs_timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      obs_lat++;
      if (is_dma ? cpu_ready : dma_ack) obs_wrong_pulse = 1'b1;
      if (is_dma ? dma_ack : cpu_ready) begin
        obs_timeout = 1'b0;
        break;
      end
      if (!sram_cen) begin
        if (obs_cen_lo == 0) begin
          obs_a = sram_a; obs_ubn = sram_ubn; obs_lbn = sram_lbn; obs_dq_o = sram_dq_o;
        end else if (sram_a !== obs_a || sram_ubn !== obs_ubn || sram_lbn !== obs_lbn ||
                     (we && sram_dq_o !== obs_dq_o)) begin
          obs_unstable = 1'b1;
        end
        obs_cen_lo++;
      end
      if (!sram_oen) obs_oen_lo++;
      if (!sram_wen) obs_wen_lo++;
      if (sram_dq_oe) obs_oe_hi++;
    end
    obs_done_ok = sram_cen && sram_oen && sram_wen && sram_ubn && sram_lbn && !sram_dq_oe;
    obs_rdata   = is_dma ? dma_rdata : {8'h00, cpu_rdata};
    cpu_req = 1'b0;
    dma_req = 1'b0;
    if (we && !obs_timeout) begin
      if (is_dma) ref_mem[int'(daddr)] = wd;
      else ref_cpu_write(caddr, wd[7:0]);
    end
  endtask

  task automatic test_reset;
    checks++; if (sram_cen !== 1'b1 || sram_oen !== 1'b1 || sram_wen !== 1'b1) begin
      errors++; $display("FAIL reset_strobes: cen/oen/wen=%b%b%b want 111", sram_cen, sram_oen, sram_wen); end
    checks++; if (sram_ubn !== 1'b1 || sram_lbn !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL reset_lanes: ubn/lbn/oe=%b%b%b want 110", sram_ubn, sram_lbn, sram_dq_oe); end
    checks++; if (cpu_ready !== 1'b0 || dma_ack !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: ready=%b ack=%b want 0 0", cpu_ready, dma_ack); end
    checks++; if (cpu_rdata !== 8'h00 || dma_rdata !== 16'h0000 || sram_a !== 19'h0) begin
      errors++; $display("FAIL reset_data: crd=%h drd=%h a=%h want 0", cpu_rdata, dma_rdata, sram_a); end
  endtask

  task automatic test_cpu_read;
    logic [19:0] addrs [2];
    addrs[0] = 20'h12345;
    addrs[1] = 20'h12344;
    for (int k = 0; k < 2; k++) begin
      xact(1'b0, 1'b0, addrs[k], 19'h0, 16'h0);
      checks++; if (obs_timeout || obs_wrong_pulse || obs_lat != WAITS + 1) begin
        errors++; $display("FAIL cpu_rd_latency: lat=%0d to=%b wrong=%b want %0d", obs_lat, obs_timeout, obs_wrong_pulse, WAITS + 1); end
      checks++; if (obs_a !== addrs[k][19:1] || obs_ubn !== addrs[k][0] || obs_lbn !== ~addrs[k][0]) begin
        errors++; $display("FAIL cpu_rd_addr: a=%h ubn=%b lbn=%b want %h %b %b", obs_a, obs_ubn, obs_lbn, addrs[k][19:1], addrs[k][0], ~addrs[k][0]); end
      checks++; if (obs_oen_lo != WAITS || obs_wen_lo != 0 || obs_oe_hi != 0 || obs_unstable) begin
        errors++; $display("FAIL cpu_rd_strobes: oen_lo=%0d wen_lo=%0d oe=%0d unst=%b", obs_oen_lo, obs_wen_lo, obs_oe_hi, obs_unstable); end
      checks++; if (obs_rdata[7:0] !== ref_cpu_byte(addrs[k])) begin
        errors++; $display("FAIL cpu_rd_data: got %h want %h", obs_rdata[7:0], ref_cpu_byte(addrs[k])); end
      checks++; if (!obs_done_ok) begin
        errors++; $display("FAIL cpu_rd_done: strobes not idle in completion cycle (got 0 want 1)"); end
    end
  endtask

  task automatic test_cpu_write;
    logic [7:0] lo_before;
    lo_before = ref_cpu_byte(20'h00011);
    xact(1'b0, 1'b1, 20'h00010, 19'h0, 16'h007E);
    checks++; if (obs_timeout || obs_lat != WAITS + 1) begin
      errors++; $display("FAIL cpu_wr_latency: lat=%0d to=%b want %0d", obs_lat, obs_timeout, WAITS + 1); end
    checks++; if (obs_a !== 19'h00008 || obs_ubn !== 1'b0 || obs_lbn !== 1'b1) begin
      errors++; $display("FAIL cpu_wr_addr: a=%h ubn=%b lbn=%b want 00008 0 1", obs_a, obs_ubn, obs_lbn); end
    checks++; if (obs_dq_o !== 16'h7E7E || obs_unstable) begin
      errors++; $display("FAIL cpu_wr_data: dq_o=%h unst=%b want 7e7e", obs_dq_o, obs_unstable); end
    checks++; if (obs_oe_hi != WAITS || obs_oen_lo != 0 || obs_cen_lo != WAITS) begin
      errors++; $display("FAIL cpu_wr_oe: oe_hi=%0d oen_lo=%0d cen_lo=%0d want %0d 0 %0d", obs_oe_hi, obs_oen_lo, obs_cen_lo, WAITS, WAITS); end
    checks++; if (obs_wen_lo != ((WAITS > 1) ? WAITS - 1 : 1)) begin
      errors++; $display("FAIL cpu_wr_wen: wen_lo=%0d want %0d", obs_wen_lo, (WAITS > 1) ? WAITS - 1 : 1); end
    xact(1'b0, 1'b0, 20'h00010, 19'h0, 16'h0);
    checks++; if (obs_rdata[7:0] !== 8'h7E) begin
      errors++; $display("FAIL cpu_wr_readback: got %h want 7e", obs_rdata[7:0]); end
    xact(1'b0, 1'b0, 20'h00011, 19'h0, 16'h0);
    checks++; if (obs_rdata[7:0] !== lo_before) begin
      errors++; $display("FAIL cpu_wr_other_lane: got %h want %h", obs_rdata[7:0], lo_before); end
  endtask

  task automatic test_dma;
    xact(1'b1, 1'b1, 20'h0, 19'h00100, 16'hBEEF);
    checks++; if (obs_timeout || obs_wrong_pulse || obs_lat != WAITS + 1) begin
      errors++; $display("FAIL dma_wr_ack: lat=%0d to=%b cpu_ready=%b want %0d", obs_lat, obs_timeout, obs_wrong_pulse, WAITS + 1); end
    checks++; if (obs_a !== 19'h00100 || obs_ubn !== 1'b0 || obs_lbn !== 1'b0 || obs_dq_o !== 16'hBEEF) begin
      errors++; $display("FAIL dma_wr_pins: a=%h ubn=%b lbn=%b dq=%h want 00100 0 0 beef", obs_a, obs_ubn, obs_lbn, obs_dq_o); end
    xact(1'b1, 1'b0, 20'h0, 19'h00100, 16'h0);
    checks++; if (obs_timeout || obs_wrong_pulse) begin
      errors++; $display("FAIL dma_rd_ack: to=%b cpu_ready=%b want 0 0", obs_timeout, obs_wrong_pulse); end
    checks++; if (obs_rdata !== 16'hBEEF || obs_ubn !== 1'b0 || obs_lbn !== 1'b0) begin
      errors++; $display("FAIL dma_rd_data: got %h ubn=%b lbn=%b want beef 0 0", obs_rdata, obs_ubn, obs_lbn); end
  endtask

  task automatic test_burst;
    byte got [$];
    int  when [$];
    byte exp;
    int  cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00300;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 19'h00400;
    for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
      @(posedge clk); #1;
      if (cpu_ready || dma_ack) begin
        got.push_back(cpu_ready ? "C" : "D");
        when.push_back(cyc);
        checks++; if (sram_cen !== 1'b1 || (cpu_ready && dma_ack)) begin
          errors++; $display("FAIL burst_done: cen=%b both=%b want 1 0", sram_cen, cpu_ready && dma_ack); end
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    checks++; if (got.size() != 10) begin
      errors++; $display("FAIL burst_count: got %0d grants want 10", got.size()); end
    cnt = 0;
    for (int k = 0; k < got.size(); k++) begin
      if (cnt == CPU_BURST) begin exp = "D"; cnt = 0; end
      else begin exp = "C"; cnt++; end
      checks++; if (got[k] != exp) begin
        errors++; $display("FAIL burst_order[%0d]: got %c want %c", k, got[k], exp); end
      if (k > 0) begin
        checks++; if (when[k] - when[k-1] != WAITS + 2) begin
          errors++; $display("FAIL burst_period[%0d]: got %0d want %0d", k, when[k] - when[k-1], WAITS + 2); end
      end
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00030; cpu_wdata = 8'h55;
    @(posedge clk); #1;
    checks++; if (sram_cen !== 1'b0 || sram_wen !== 1'b0) begin
      errors++; $display("FAIL rstmid_started: cen=%b wen=%b want 0 0", sram_cen, sram_wen); end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++; if (sram_cen !== 1'b1 || sram_oen !== 1'b1 || sram_wen !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: cen/oen/wen/oe=%b%b%b%b want 1110", sram_cen, sram_oen, sram_wen, sram_dq_oe); end
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (cpu_ready !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_ready: ready=%b want 0", cpu_ready); end
    end
    @(negedge clk);
    rstn = 1'b1;
    xact(1'b0, 1'b0, 20'h12345, 19'h0, 16'h0);
    checks++; if (obs_timeout || obs_lat != WAITS + 1 || obs_rdata[7:0] !== ref_cpu_byte(20'h12345)) begin
      errors++; $display("FAIL rstmid_recover: to=%b lat=%0d data=%h want 0 %0d %h", obs_timeout, obs_lat, obs_rdata[7:0], WAITS + 1, ref_cpu_byte(20'h12345)); end
  endtask

  task automatic test_random;
    bit          d, we;
    logic [18:0] wa;
    logic [19:0] ca;
    logic [15:0] wd, exp;
    for (int k = 0; k < 40; k++) begin
      d  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      wa = 19'h00200 + 19'($urandom_range(0, 7));
      ca = {wa, 1'($urandom_range(0, 1))};
      wd = 16'($urandom);
      exp = d ? ref_rd(wa) : {8'h00, ref_cpu_byte(ca)};
      xact(d, we, ca, wa, wd);
      checks++; if (obs_timeout || obs_wrong_pulse || obs_lat != WAITS + 1) begin
        errors++; $display("FAIL rand_done[%0d]: to=%b wrong=%b lat=%0d want %0d", k, obs_timeout, obs_wrong_pulse, obs_lat, WAITS + 1); end
      if (!we) begin
        checks++; if (obs_rdata !== exp) begin
          errors++; $display("FAIL rand_rdata[%0d]: dma=%b got %h want %h", k, d, obs_rdata, exp); end
      end
    end
  endtask

  task automatic test_waits1;
    int lat, cen_lo, wen_lo, t0, t1;
    logic [7:0]  rd;
    logic [15:0] w;
    @(posedge clk); #1;
    w1_cpu_req = 1'b1; w1_cpu_we = 1'b1; w1_cpu_addr = 20'h00041; w1_cpu_wdata = 8'hC3;
    lat = 0; cen_lo = 0; wen_lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (w1_cpu_ready) break;
      if (!w1_sram_cen) cen_lo++;
      if (!w1_sram_wen) wen_lo++;
    end
    w1_cpu_req = 1'b0;
    checks++; if (w1_cpu_ready !== 1'b1 || lat != 2) begin
      errors++; $display("FAIL w1_latency: ready=%b lat=%0d want 1 2", w1_cpu_ready, lat); end
    checks++; if (cen_lo != 1 || wen_lo != 1) begin
      errors++; $display("FAIL w1_strobes: cen_lo=%0d wen_lo=%0d want 1 1", cen_lo, wen_lo); end
    @(posedge clk); #1;
    w1_cpu_req = 1'b1; w1_cpu_we = 1'b0;
    t0 = -1; t1 = -1; rd = 8'h00;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      @(posedge clk); #1;
      if (w1_cpu_ready) begin
        if (t0 < 0) begin t0 = i; rd = w1_cpu_rdata; end
        else t1 = i;
      end
    end
    w1_cpu_req = 1'b0;
    w = 16'h0020 ^ 16'h1234;
    checks++; if (t0 < 0 || t1 - t0 != 3) begin
      errors++; $display("FAIL w1_period: got %0d want 3", t1 - t0); end
    checks++; if (rd !== w[7:0]) begin
      errors++; $display("FAIL w1_rdata: got %h want %h", rd, w[7:0]); end
  endtask

  initial begin
    rstn = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    w1_cpu_req = 1'b0; w1_cpu_we = 1'b0; w1_cpu_addr = '0; w1_cpu_wdata = '0;
    w1_dma_req = 1'b0; w1_dma_we = 1'b0; w1_dma_addr = '0; w1_dma_wdata = '0;
    #22;
    test_reset;
    rstn = 1'b1;
    test_cpu_read;
    test_cpu_write;
    test_dma;
    test_burst;
    test_reset_mid;
    test_random;
    test_waits1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single external 16-bit SRAM between the CPU, a byte-oriented requester that drives mapped 20-bit physical addresses, and a 16-bit DMA requester for disk/serial block transfers. The block sequences every SRAM access (address/data hold, chip select, output enable, write strobe, byte lanes) and handles the turnaround between accesses. It arbitrates with CPU priority and a starvation guard for DMA. It sits between the mapper output and the SRAM pins.

Parameters:
WAITS, 2, SRAM access length in clk cycles (>=1)
CPU_BURST, 4, max consecutive CPU grants while DMA is pending

Ports:
One clock; reset is asynchronous and active-low.
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, level, held until cpu_ready
cpu_we  in  1  1 = write
cpu_addr  in  20  physical byte address (mapper output concatenated with offset)
cpu_wdata  in  8  write byte
cpu_rdata  out  8  read byte, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
dma_req  in  1  DMA request, level, held until dma_ack
dma_we  in  1  1 = write
dma_addr  in  19  word address
dma_wdata  in  16  write word
dma_rdata  out  16  read word, valid while dma_ack=1
dma_ack  out  1  one-cycle completion pulse
sram_a  out  19  SRAM word address
sram_dq_o  out  16  write data
sram_dq_i  in  16  read data
sram_dq_oe  out  1  1 = FPGA drives DQ
sram_cen, sram_oen, sram_wen  out  1 each  active-low strobes
sram_ubn, sram_lbn  out  1 each  active-low byte enables (ub = dq[15:8])

Behaviour:
- Reset (async, rstn=0): state IDLE; cen/oen/wen/ubn/lbn=1; dq_oe=0; cpu_ready=dma_ack=0; rdata=0; sram_a=0; burst counter=0. An access in flight is abandoned and produces no completion pulse.
- All outputs are registered. FSM states: IDLE, ACCESS, DONE.
- IDLE: at the clock edge, pick a requester if any. Go to ACCESS with address, data, lanes and direction latched. With no request, stay in IDLE.
- Priority: CPU wins ties unless dma_req=1 and the burst counter equals CPU_BURST. The counter increments on each CPU grant made while dma_req=1. It clears on a DMA grant or whenever dma_req=0 in IDLE.
- ACCESS lasts exactly WAITS cycles, counted by an internal counter. cen=0 throughout. Address and lanes are stable.
  - Read: oen=0, dq_oe=0. sram_dq_i is captured at the final ACCESS edge.
  - Write: dq_oe=1 and data stable for the whole ACCESS. wen=0 for the first max(WAITS-1,1) cycles. When WAITS>1, wen=1 in the last cycle (hold time).
- DONE: exactly one cycle. All strobes are high and dq_oe=0 (bus turnaround). The granted side's ready/ack=1 with rdata valid. Requests are not sampled in DONE. Next state is IDLE.
- Latency: a request sampled in IDLE produces its completion pulse WAITS+1 cycles later. Back-to-back accesses repeat every WAITS+2 cycles.
- Requester rule: drop req, or present a new transaction, on the edge where ready/ack is seen. Inputs are ignored outside IDLE.
- CPU byte mapping (big-endian 99xx): sram_a=cpu_addr[19:1].
  - cpu_addr[0]=0 selects the upper byte: ubn=0, lbn=1.
  - cpu_addr[0]=1 selects the lower byte: lbn=0, ubn=1.
  - Write data is replicated on both halves ({wdata,wdata}).
  - Read returns the selected half.
- DMA: both lanes enabled, full word.
- cpu_rdata/dma_rdata hold their last value outside DONE. Only the ready/ack pulse qualifies them.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/DONE), grant enum (GNT_CPU/GNT_DMA), SRAM address width constant 19.
- No sub-module required. The WAITS cycle counter and the burst counter stay inline.

Test Plan:
- CPU read, WAITS=2: SRAM word 0x091A2=0xA55A, cpu_addr=0x12345 -> sram_a=0x091A2, lbn=0, ubn=1, oen low 2 cycles, cpu_ready 3 cycles after sampling, cpu_rdata=0x5A. Same with cpu_addr=0x12344 -> ubn=0, rdata=0xA5.
- CPU write 0x7E to 0x00010 -> sram_a=0x00008, ubn=0, lbn=1, dq_o=0x7E7E, dq_oe=1 for 2 cycles, wen low exactly 1 cycle; read-back returns 0x7E and the lower byte is unchanged.
- DMA write 0xBEEF to word 0x00100, then DMA read -> dma_ack pulses, dma_rdata=0xBEEF, both lanes low, cpu_ready never asserted.
- Both requests held continuously, CPU_BURST=4 -> grant order C,C,C,C,D,C,C,C,C,D. One grant every 4 cycles, cen high in every DONE cycle.
- rstn pulled low in the second ACCESS cycle of a CPU write -> wen/cen/oen high and dq_oe=0 immediately (asynchronous), no cpu_ready. After release, a new request completes normally.
- WAITS=1 -> ACCESS 1 cycle, write wen low 1 cycle, completion 2 cycles after sampling, period 3 cycles.
